// File: rtl/if_id_inst_queue_pkg.sv
// Shared constants and the entry record for the IF->ID instruction queue.
package if_id_inst_queue_pkg;

    localparam logic [31:0] INST_NOP     = 32'h0340_0000;  // andi r0,r0,0
    localparam int          INST_Q_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } iq_entry_t;

endpackage

// File: rtl/if_id_inst_queue.sv
// Circular-buffer instruction queue between fetch and decode with a valid/ready
// handshake on both sides and a single-cycle flush for redirects.
module if_id_inst_queue
    import if_id_inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_Q_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             fs_valid,
    output logic             fs_ready,
    input  logic [31:0]      fs_pc,
    input  logic [31:0]      fs_inst,
    input  logic             fs_adef,
    output logic             ds_valid,
    input  logic             ds_ready,
    output logic [31:0]      ds_pc,
    output logic [31:0]      ds_inst,
    output logic             ds_adef,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    iq_entry_t        mem_q [DEPTH];
    iq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic full, empty, push, pop;
    iq_entry_t head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // fs_ready looks only at local occupancy so ID never reaches IF combinationally.
    assign push  = fs_valid && !full && !flush;
    assign pop   = !empty && ds_ready && !flush;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: fs_pc, inst: fs_inst, adef: fs_adef};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        fs_ready = !full;
        ds_valid = !empty && !flush;
        count    = count_q;
        ds_pc    = 32'h0;
        ds_inst  = INST_NOP;
        ds_adef  = 1'b0;
        if (!empty) begin
            ds_pc   = head.pc;
            ds_inst = head.inst;
            ds_adef = head.adef;
        end
    end

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Directed vector bench for if_id_inst_queue: table of per-cycle vectors plus
// hand-written streaming/wrap and asynchronous-reset sequences.
module tb_if_id_inst_queue;
    import if_id_inst_queue_pkg::*;

    typedef struct {
        logic        flush;
        logic        fs_valid;
        logic [31:0] fs_pc;
        logic [31:0] fs_inst;
        logic        fs_adef;
        logic        ds_ready;
        logic        e_ds_valid;
        logic        e_fs_ready;
        logic [31:0] e_ds_pc;
        logic [31:0] e_ds_inst;
        logic        e_ds_adef;
        logic [2:0]  e_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush, fs_valid, fs_adef, ds_ready;
    logic [31:0] fs_pc, fs_inst;
    logic        fs_ready, ds_valid, ds_adef;
    logic [31:0] ds_pc, ds_inst;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [14];

    always #5 clk = ~clk;

    if_id_inst_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fs_valid(fs_valid), .fs_ready(fs_ready), .fs_pc(fs_pc),
        .fs_inst(fs_inst), .fs_adef(fs_adef),
        .ds_valid(ds_valid), .ds_ready(ds_ready), .ds_pc(ds_pc),
        .ds_inst(ds_inst), .ds_adef(ds_adef), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic fl, input logic fv, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic adef, input logic dr,
                                 input logic edv, input logic efr, input logic [31:0] epc,
                                 input logic [31:0] einst, input logic eadef, input logic [2:0] ecnt);
        vec_t v;
        v.flush = fl; v.fs_valid = fv; v.fs_pc = pc; v.fs_inst = inst; v.fs_adef = adef;
        v.ds_ready = dr; v.e_ds_valid = edv; v.e_fs_ready = efr; v.e_ds_pc = epc;
        v.e_ds_inst = einst; v.e_ds_adef = eadef; v.e_count = ecnt;
        return v;
    endfunction

    task automatic check_outs(input string tag, input logic edv, input logic efr,
                              input logic [31:0] epc, input logic [31:0] einst,
                              input logic eadef, input logic [2:0] ecnt);
        chk({tag, ".ds_valid"}, 32'(ds_valid), 32'(edv));
        chk({tag, ".fs_ready"}, 32'(fs_ready), 32'(efr));
        chk({tag, ".ds_pc"},    ds_pc,         epc);
        chk({tag, ".ds_inst"},  ds_inst,       einst);
        chk({tag, ".ds_adef"},  32'(ds_adef),  32'(eadef));
        chk({tag, ".count"},    32'(count),    32'(ecnt));
    endtask

    initial begin
        // Each vector: inputs held for one cycle; expectations are sampled before the edge.
        //            fl fv pc            inst          ad dr | dv fr pc            inst          ad cnt
        vecs[0]  = mkv(0, 1, 32'h1c000000, 32'h0000_1000, 0, 0,  0, 1, 32'h0,        INST_NOP,      0, 0);
        vecs[1]  = mkv(0, 1, 32'h1c000004, 32'h0000_1004, 0, 0,  1, 1, 32'h1c000000, 32'h0000_1000, 0, 1);
        vecs[2]  = mkv(0, 1, 32'h1c000008, 32'h0000_1008, 0, 0,  1, 1, 32'h1c000000, 32'h0000_1000, 0, 2);
        vecs[3]  = mkv(0, 1, 32'h1c00000c, 32'h0000_100c, 0, 0,  1, 1, 32'h1c000000, 32'h0000_1000, 0, 3);
        vecs[4]  = mkv(0, 1, 32'h1c000010, 32'h0000_1010, 0, 0,  1, 0, 32'h1c000000, 32'h0000_1000, 0, 4);
        vecs[5]  = mkv(0, 1, 32'h1c000010, 32'h0000_1010, 0, 1,  1, 0, 32'h1c000000, 32'h0000_1000, 0, 4);
        vecs[6]  = mkv(0, 1, 32'h1c000010, 32'h0000_1010, 0, 0,  1, 1, 32'h1c000004, 32'h0000_1004, 0, 3);
        vecs[7]  = mkv(0, 0, 32'h0,        32'h0,         0, 0,  1, 0, 32'h1c000004, 32'h0000_1004, 0, 4);
        vecs[8]  = mkv(0, 0, 32'h0,        32'h0,         0, 1,  1, 0, 32'h1c000004, 32'h0000_1004, 0, 4);
        vecs[9]  = mkv(1, 1, 32'h1c000014, 32'h0000_1014, 0, 1,  0, 1, 32'h1c000008, 32'h0000_1008, 0, 3);
        vecs[10] = mkv(0, 0, 32'h0,        32'h0,         0, 0,  0, 1, 32'h0,        INST_NOP,      0, 0);
        vecs[11] = mkv(0, 1, 32'h1c000100, 32'h02800c21,  1, 0,  0, 1, 32'h0,        INST_NOP,      0, 0);
        vecs[12] = mkv(0, 0, 32'h0,        32'h0,         0, 1,  1, 1, 32'h1c000100, 32'h02800c21,  1, 1);
        vecs[13] = mkv(0, 0, 32'h0,        32'h0,         0, 0,  0, 1, 32'h0,        INST_NOP,      0, 0);

        reset = 1'b1; flush = 0; fs_valid = 0; fs_pc = 0; fs_inst = 0; fs_adef = 0; ds_ready = 0;
        #1;
        check_outs("reset0", 0, 1, 32'h0, INST_NOP, 0, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            flush = vecs[i].flush; fs_valid = vecs[i].fs_valid; fs_pc = vecs[i].fs_pc;
            fs_inst = vecs[i].fs_inst; fs_adef = vecs[i].fs_adef; ds_ready = vecs[i].ds_ready;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_ds_valid, vecs[i].e_fs_ready,
                       vecs[i].e_ds_pc, vecs[i].e_ds_inst, vecs[i].e_ds_adef, vecs[i].e_count);
            @(negedge clk);
        end

        // Streaming: push and pop every cycle; pointers wrap several times.
        fs_adef = 0; ds_ready = 1;
        for (int k = 0; k < 21; k++) begin
            fs_valid = 1'b1;
            fs_pc    = 32'h1c001000 + 32'(4 * k);
            fs_inst  = 32'h0000_2000 + 32'(k);
            #1;
            if (k == 0) begin
                chk("stream0.count", 32'(count), 32'd0);
                chk("stream0.ds_valid", 32'(ds_valid), 32'd0);
            end else begin
                chk($sformatf("stream%0d.ds_pc", k), ds_pc, 32'h1c001000 + 32'(4 * (k - 1)));
                chk($sformatf("stream%0d.ds_inst", k), ds_inst, 32'h0000_2000 + 32'(k - 1));
                chk($sformatf("stream%0d.count", k), 32'(count), 32'd1);
                chk($sformatf("stream%0d.ds_valid", k), 32'(ds_valid), 32'd1);
            end
            @(negedge clk);
        end

        // Build up occupancy, then assert reset between edges.
        ds_ready = 0; fs_valid = 1; fs_pc = 32'h1c00_2000; fs_inst = 32'h0000_3000;
        @(negedge clk);
        fs_valid = 0;
        #1;
        chk("prerst.count", 32'(count), 32'd2);
        #2 reset = 1'b1;
        #1;
        check_outs("async_rst", 0, 1, 32'h0, INST_NOP, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("post_rst", 0, 1, 32'h0, INST_NOP, 0, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
